// File: rtl/gat_bram_loader_if.sv
// Word stream into the GAT BRAM loader: 32-bit data with valid/ready handshake
// and an end-of-segment marker.
interface gat_bram_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/gat_bram_loader.sv
// Framed-segment load engine: parses header+payload words from the stream and
// writes the H-data, node-info or weight BRAM port with byte addresses.
module gat_bram_loader #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned H_DATA_WIDTH     = 19,
  parameter int unsigned NODE_INFO_WIDTH  = 20,
  parameter int unsigned H_DATA_DEPTH     = 242101,
  parameter int unsigned NODE_INFO_DEPTH  = 13264,
  parameter int unsigned WEIGHT_DEPTH     = 22928,
  parameter int unsigned H_DATA_ADDR_W    = 18,
  parameter int unsigned NODE_INFO_ADDR_W = 14,
  parameter int unsigned WEIGHT_ADDR_W    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  gat_bram_loader_if.slave              s,
  output logic [H_DATA_WIDTH-1:0]       h_data_bram_din,
  output logic                          h_data_bram_ena,
  output logic                          h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0]    h_node_info_bram_din,
  output logic                          h_node_info_bram_ena,
  output logic                          h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
  output logic [DATA_WIDTH-1:0]         wgt_bram_din,
  output logic                          wgt_bram_ena,
  output logic                          wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
  output logic                          h_data_bram_load_done,
  output logic                          h_node_info_bram_load_done,
  output logic                          wgt_bram_load_done,
  output logic                          load_err
);

  typedef enum logic [1:0] {HDR, DATA, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic        rdy_q;
  logic        ready, xfer, hdr_bad, last_word;
  logic        load_hdr, wr_en, err_set, done_set;
  logic        by_count_q, by_count_d;
  logic [1:0]  hdr_tgt, tgt_q;
  logic [29:0] hdr_cnt, cnt_q, idx_q;

  assign hdr_tgt = s.s_data[31:30];
  assign hdr_cnt = s.s_data[29:0];

  always_comb begin
    hdr_bad = 1'b1;
    unique case (hdr_tgt)
      2'd0:    hdr_bad = (hdr_cnt > 30'(H_DATA_DEPTH));
      2'd1:    hdr_bad = (hdr_cnt > 30'(NODE_INFO_DEPTH));
      2'd2:    hdr_bad = (hdr_cnt > 30'(WEIGHT_DEPTH));
      default: hdr_bad = 1'b1;
    endcase
    if (hdr_cnt == '0) hdr_bad = 1'b1;
  end

  // rdy_q keeps s_ready low for the cycle after rst; clear re-opens it at once.
  assign ready     = rdy_q & (state_q != FIN);
  assign s.s_ready = ready;
  assign xfer      = s.s_valid & ready;
  assign last_word = (idx_q == cnt_q - 30'd1);

  always_comb begin
    state_d    = state_q;
    by_count_d = by_count_q;
    load_hdr   = 1'b0;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    unique case (state_q)
      HDR: begin
        if (xfer) begin
          if (hdr_bad) begin
            err_set = 1'b1;
            state_d = DRAIN;
          end else begin
            load_hdr = 1'b1;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (last_word) begin
            by_count_d = 1'b1;
            err_set    = ~s.s_last;
            state_d    = FIN;
          end else if (s.s_last) begin
            by_count_d = 1'b0;
            err_set    = 1'b1;
            state_d    = FIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && s.s_last) state_d = HDR;
      end
      FIN: begin
        done_set = by_count_q;
        state_d  = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR;
      rdy_q      <= 1'b0;
      by_count_q <= 1'b0;
    end else if (clear) begin
      state_q    <= HDR;
      rdy_q      <= 1'b1;
      by_count_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      by_count_q <= by_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tgt_q                      <= '0;
      cnt_q                      <= '0;
      idx_q                      <= '0;
      h_data_bram_din            <= '0;
      h_data_bram_ena            <= 1'b0;
      h_data_bram_wea            <= 1'b0;
      h_data_bram_addra          <= '0;
      h_node_info_bram_din       <= '0;
      h_node_info_bram_ena       <= 1'b0;
      h_node_info_bram_wea       <= 1'b0;
      h_node_info_bram_addra     <= '0;
      wgt_bram_din               <= '0;
      wgt_bram_ena               <= 1'b0;
      wgt_bram_wea               <= 1'b0;
      wgt_bram_addra             <= '0;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
      load_err                   <= 1'b0;
    end else begin
      h_data_bram_ena      <= 1'b0;
      h_data_bram_wea      <= 1'b0;
      h_node_info_bram_ena <= 1'b0;
      h_node_info_bram_wea <= 1'b0;
      wgt_bram_ena         <= 1'b0;
      wgt_bram_wea         <= 1'b0;
      if (load_hdr) begin
        tgt_q <= hdr_tgt;
        cnt_q <= hdr_cnt;
        idx_q <= '0;
      end
      if (wr_en) begin
        idx_q <= idx_q + 30'd1;
        unique case (tgt_q)
          2'd0: begin
            h_data_bram_din   <= s.s_data[H_DATA_WIDTH-1:0];
            h_data_bram_addra <= {idx_q[H_DATA_ADDR_W-1:0], 2'b00};
            h_data_bram_ena   <= 1'b1;
            h_data_bram_wea   <= 1'b1;
          end
          2'd1: begin
            h_node_info_bram_din   <= s.s_data[NODE_INFO_WIDTH-1:0];
            h_node_info_bram_addra <= {idx_q[NODE_INFO_ADDR_W-1:0], 2'b00};
            h_node_info_bram_ena   <= 1'b1;
            h_node_info_bram_wea   <= 1'b1;
          end
          default: begin
            wgt_bram_din   <= s.s_data[DATA_WIDTH-1:0];
            wgt_bram_addra <= {idx_q[WEIGHT_ADDR_W-1:0], 2'b00};
            wgt_bram_ena   <= 1'b1;
            wgt_bram_wea   <= 1'b1;
          end
        endcase
      end
      if (err_set) load_err <= 1'b1;
      if (done_set) begin
        unique case (tgt_q)
          2'd0:    h_data_bram_load_done      <= 1'b1;
          2'd1:    h_node_info_bram_load_done <= 1'b1;
          default: wgt_bram_load_done         <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gat_bram_loader.sv
// Bench for gat_bram_loader: vector table, directed timing sequences and random
// framed streams checked against a transaction-level parser model.
module tb_gat_bram_loader;
  logic clk = 1'b0;
  logic rst, clear;
  logic [18:0] h_din;  logic h_ena, h_wea;  logic [19:0] h_addr;
  logic [19:0] n_din;  logic n_ena, n_wea;  logic [15:0] n_addr;
  logic [7:0]  w_din;  logic w_ena, w_wea;  logic [16:0] w_addr;
  logic h_done, n_done, w_done, err;

  gat_bram_loader_if sif();

  gat_bram_loader dut (
    .clk(clk), .rst(rst), .clear(clear), .s(sif.slave),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea),
    .h_data_bram_addra(h_addr),
    .h_node_info_bram_din(n_din), .h_node_info_bram_ena(n_ena),
    .h_node_info_bram_wea(n_wea), .h_node_info_bram_addra(n_addr),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea),
    .wgt_bram_addra(w_addr),
    .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(n_done),
    .wgt_bram_load_done(w_done), .load_err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [41:0] act_q[$];
  logic [41:0] exp_q[$];
  logic [31:0] sw[$];
  bit          sl[$];
  logic [2:0]  m_done;
  logic        m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: one-hot strobes, wea tracks ena, every write logged.
  always @(negedge clk) begin
    if (h_ena || n_ena || w_ena) begin
      checks++;
      if ((32'(h_ena) + 32'(n_ena) + 32'(w_ena)) > 1 || h_wea != h_ena || n_wea != n_ena ||
          w_wea != w_ena) begin
        errors++;
        $display("FAIL strobe_onehot actual=%b%b%b/%b%b%b required=one-hot with wea==ena",
                 h_ena, n_ena, w_ena, h_wea, n_wea, w_wea);
      end
      if (h_ena) act_q.push_back({2'd0, 20'(h_addr), 20'(h_din)});
      if (n_ena) act_q.push_back({2'd1, 20'(n_addr), 20'(n_din)});
      if (w_ena) act_q.push_back({2'd2, 20'(w_addr), 20'(w_din)});
    end
  end

  function automatic int unsigned depth_of(input int unsigned t);
    case (t)
      0: return 242101;
      1: return 13264;
      2: return 22928;
      default: return 0;
    endcase
  endfunction

  function automatic logic [19:0] mask_of(input int unsigned t, input logic [31:0] w);
    case (t)
      0: return 20'(w[18:0]);
      1: return w[19:0];
      default: return 20'(w[7:0]);
    endcase
  endfunction

  // Reference parser over the whole stream sw/sl, starting from a fresh header.
  task automatic model_run();
    int unsigned i = 0;
    exp_q.delete();
    m_done = '0;
    m_err  = 1'b0;
    while (i < sw.size()) begin
      int unsigned t = int'(sw[i][31:30]);
      int unsigned n = int'(sw[i][29:0]);
      i++;
      if (t == 3 || n == 0 || n > depth_of(t)) begin
        m_err = 1'b1;
        while (i < sw.size()) begin
          bit l = sl[i];
          i++;
          if (l) break;
        end
      end else begin
        for (int unsigned k = 0; k < n && i < sw.size(); k++) begin
          bit l = sl[i];
          exp_q.push_back({2'(t), 20'(k * 4), mask_of(t, sw[i])});
          i++;
          if (k == n - 1) begin
            m_done[t] = 1'b1;
            if (!l) m_err = 1'b1;
          end else if (l) begin
            m_err = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic put(input logic [31:0] w, input bit l);
    int unsigned tries = 0;
    sif.s_data  = w;
    sif.s_last  = l;
    sif.s_valid = 1'b1;
    while (!sif.s_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) chk("handshake_timeout", 64'(tries), 64'd0);
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic send_stream(input int unsigned gap_max);
    for (int i = 0; i < sw.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      put(sw[i], sl[i]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    act_q.delete();
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({tag, "_write"}, 64'(act_q[i]), 64'(exp_q[i]));
  endtask

  typedef struct {
    logic [31:0] hdr;
    int unsigned nwords;
    int unsigned last_at;
    int unsigned exp_writes;
    logic [2:0]  exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_0003, 3, 3, 3, 3'b001, 1'b0};
    vecs[1] = '{32'h8000_0002, 2, 2, 2, 3'b100, 1'b0};
    vecs[2] = '{32'h4000_0004, 2, 2, 2, 3'b000, 1'b1};
    vecs[3] = '{32'hC000_0001, 2, 2, 0, 3'b000, 1'b1};
    vecs[4] = '{32'h0003_B1B6, 1, 1, 0, 3'b000, 1'b1};
    vecs[5] = '{32'h0000_0000, 1, 1, 0, 3'b000, 1'b1};
    vecs[6] = '{32'h4000_0001, 1, 0, 1, 3'b010, 1'b1};
    vecs[7] = '{32'h4000_33D1, 3, 3, 0, 3'b000, 1'b1};

    rst = 1'b1; clear = 1'b0;
    sif.s_data = '0; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(sif.s_ready), 64'd0);
    chk("reset_flags", 64'({h_done, n_done, w_done, err}), 64'd0);
    chk("reset_ports", 64'({h_ena, n_ena, w_ena, h_addr, n_addr, w_addr, h_din}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back H-data segment: write one cycle after each handshake, then FIN.
    pulse_clear();
    put(32'h0000_0003, 1'b0);
    put(32'hFFFA_0011, 1'b0);
    chk("t1_w0", 64'({h_ena, h_addr, h_din}), 64'({1'b1, 20'h0, 19'h20011}));
    put(32'h1234_5678, 1'b0);
    chk("t1_w1", 64'({h_ena, h_addr, h_din}), 64'({1'b1, 20'h4, 19'h45678}));
    put(32'h0000_0ABC, 1'b1);
    chk("t1_w2", 64'({h_ena, h_addr, h_din}), 64'({1'b1, 20'h8, 19'h00ABC}));
    chk("t1_fin_ready", 64'(sif.s_ready), 64'd0);
    @(negedge clk);
    chk("t1_after_fin", 64'({sif.s_ready, h_ena, h_done, err}), 64'b1010);

    // Weight segment with idle gaps: strobes only on handshake+1.
    pulse_clear();
    put(32'h8000_0002, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_idle", 64'({h_ena, n_ena, w_ena}), 64'd0);
    put(32'h0000_01A5, 1'b0);
    chk("t2_w0", 64'({h_ena, n_ena, w_ena, w_addr, w_din}), 64'({3'b001, 17'h0, 8'hA5}));
    repeat (2) @(negedge clk);
    chk("t2_gap", 64'(w_ena), 64'd0);
    put(32'h0000_003C, 1'b1);
    chk("t2_w1", 64'({w_ena, w_addr, w_din}), 64'({1'b1, 17'h4, 8'h3C}));
    @(negedge clk);
    chk("t2_done", 64'({h_done, n_done, w_done, err}), 64'b0010);

    // Table: each segment followed by a valid weight segment to show the header re-parse.
    foreach (vecs[v]) begin
      pulse_clear();
      sw.delete(); sl.delete();
      sw.push_back(vecs[v].hdr); sl.push_back(1'b0);
      for (int unsigned k = 1; k <= vecs[v].nwords; k++) begin
        sw.push_back($urandom);
        sl.push_back(k == vecs[v].last_at);
      end
      sw.push_back(32'h8000_0001); sl.push_back(1'b0);
      sw.push_back($urandom);      sl.push_back(1'b1);
      model_run();
      send_stream(1);
      chk($sformatf("vec%0d_nwrites", v), 64'(act_q.size()), 64'(vecs[v].exp_writes + 1));
      compare_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_done", v), 64'({w_done, n_done, h_done}),
          64'(vecs[v].exp_done | 3'b100));
      chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
    end

    // Reset mid-segment, then reload from address 0.
    pulse_clear();
    put(32'h0000_000A, 1'b0);
    for (int k = 0; k < 4; k++) put(32'h100 + 32'(k), 1'b0);
    sif.s_data = 32'h105; sif.s_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    sif.s_valid = 1'b0; rst = 1'b0;
    chk("t5_rst_ports", 64'({sif.s_ready, h_ena, h_addr, h_din, h_done, err}), 64'd0);
    put(32'h0000_0002, 1'b0);
    put(32'h0000_0077, 1'b0);
    chk("t5_restart", 64'({h_ena, h_addr, h_din}), 64'({1'b1, 20'h0, 19'h77}));
    put(32'h0000_0078, 1'b1);
    @(negedge clk);
    chk("t5_done", 64'({h_done, err}), 64'b10);

    // All three targets, reload of a done target, then clear.
    pulse_clear();
    sw.delete(); sl.delete();
    for (int t = 0; t < 3; t++) begin
      sw.push_back({2'(t), 30'd2}); sl.push_back(1'b0);
      sw.push_back($urandom);       sl.push_back(1'b0);
      sw.push_back($urandom);       sl.push_back(1'b1);
    end
    sw.push_back(32'h0000_0001); sl.push_back(1'b0);
    sw.push_back($urandom);      sl.push_back(1'b1);
    model_run();
    send_stream(0);
    compare_writes("t6");
    chk("t6_flags", 64'({h_done, n_done, w_done, err}), 64'b1110);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t6_cleared", 64'({h_done, n_done, w_done, err}), 64'd0);
    chk("t6_ready", 64'(sif.s_ready), 64'd1);

    // Random framed streams against the model.
    for (int it = 0; it < 25; it++) begin
      pulse_clear();
      sw.delete(); sl.delete();
      repeat ($urandom_range(2, 6)) begin
        int unsigned kind = $urandom_range(0, 9);
        int unsigned t = $urandom_range(0, 2);
        int unsigned n = $urandom_range(1, 6);
        if (kind <= 2) begin
          if (kind == 0) sw.push_back({2'd3, 30'(n)});
          else if (kind == 1) sw.push_back({2'(t), 30'd0});
          else sw.push_back({2'(t), 30'(depth_of(t) + $urandom_range(1, 3))});
          sl.push_back(1'($urandom_range(0, 1)));
          n = $urandom_range(1, 3);
          for (int unsigned k = 1; k <= n; k++) begin
            sw.push_back($urandom); sl.push_back(k == n);
          end
        end else begin
          int unsigned mode = $urandom_range(0, 5);
          int unsigned len = (mode == 0 && n > 1) ? $urandom_range(1, n - 1) : n;
          sw.push_back({2'(t), 30'(n)}); sl.push_back(1'($urandom_range(0, 1)));
          for (int unsigned k = 1; k <= len; k++) begin
            sw.push_back($urandom);
            sl.push_back((k == len) && !(mode == 1));
          end
        end
      end
      model_run();
      send_stream(2);
      compare_writes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_done", it), 64'({w_done, n_done, h_done}), 64'(m_done));
      chk($sformatf("rnd%0d_err", it), 64'(err), 64'(m_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
